interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources (1..2^EXW-1).
REQ-002 SHALL have parameter EXW, default 4, meaning exception vector width presented to the CPU.
REQ-003 SHALL have parameter EDGE, default NSRC'b0, meaning per-source mode (1 = rising-edge latched, 0 = level).
REQ-004 SHALL have parameter MASK_RST, default all ones, meaning the reset value of the enable mask (1 = source enabled).
REQ-005 SHALL have port clk_i  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port src  input  NSRC  raw interrupt requests, bit i = source i.
REQ-008 SHALL have port enabled  input  1  CPU interrupt enable.
REQ-009 SHALL have port ack  input  1  one-cycle pulse: CPU has taken the presented exception.
REQ-010 SHALL have port mask_we  input  1  mask write strobe.
REQ-011 SHALL have port mask_wdata  input  NSRC  new mask value.
REQ-012 SHALL have port mask  output  NSRC  current mask.
REQ-013 SHALL have port pending  output  NSRC  current pending register.
REQ-014 SHALL have port cpu_exception  output  EXW  presented vector; 0 = none, i+1 = source i.
REQ-015 SHALL have port irq  output  1  high whenever cpu_exception != 0.

Function
REQ-016 SHALL latch edge sources: pending[i] set in the cycle after src[i] goes 0->1 (previous-sample register per source).
REQ-017 SHALL track level sources: pending[i] = registered src[i], one cycle latency.
REQ-018 SHALL treat pending bits as eligible only when mask[i]=1; masked sources keep latching pending.
REQ-019 SHALL select priority as lowest eligible index wins.
REQ-020 SHALL implement FSM states IDLE and PRESENT.
REQ-021 IDLE: if enabled=1 and any eligible bit set, next cycle enter PRESENT with cpu_exception = winner+1; else cpu_exception = 0.
REQ-022 PRESENT: cpu_exception SHALL hold constant, even if a higher-priority source arrives or the presented source drops.
REQ-023 PRESENT with ack=1: return to IDLE, cpu_exception = 0 next cycle; clear pending of the presented source if edge mode.
REQ-024 PRESENT with enabled=0 and ack=0: retract, return to IDLE with cpu_exception = 0 next cycle; pending unchanged.
REQ-025 ack in IDLE SHALL be ignored.
REQ-026 SHALL let a new rising edge on a source win over a clear from ack in the same cycle (pending stays 1).
REQ-027 SHALL apply mask_we: mask = mask_wdata next cycle; change does not retract an already-presented vector.
REQ-028 SHALL hold at least one IDLE cycle (cpu_exception = 0) between consecutive presentations.
REQ-029 SHALL detect NSRC > 2^EXW-1 as an elaboration error.

Reset
REQ-030 On rst_i=1 at a clock edge: pending = 0, edge-history registers = 0, mask = MASK_RST, FSM = IDLE, cpu_exception = 0, irq = 0.
REQ-031 SHALL apply reset mid-presentation identically; the in-flight vector is dropped, with no ack needed.
REQ-032 SHALL NOT set any edge pending bit in the first cycle after reset for a source already high at reset release.

Verification
REQ-033 NSRC=8, EDGE=0, enabled=1: pulse src[5] -> pending[5]=1; next cycle cpu_exception=6, irq=1; ack -> pending[5]=0, cpu_exception=0.
REQ-034 Priority: src[2] and src[6] edges in the same cycle -> cpu_exception=3; ack -> one IDLE cycle with 0, then 7.
REQ-035 Hold/retract: presenting 7 while src[0] asserts -> stays 7; drop enabled -> cpu_exception=0 next cycle, pending[6] still 1.
REQ-036 Mask: write mask=8'hFE, pulse src[0] -> pending[0]=1, cpu_exception stays 0; write 8'hFF -> cpu_exception=1.
REQ-037 Ack/edge collision: new src[3] rising edge in the ack cycle of vector 4 -> pending[3] stays 1 and is re-presented after the IDLE cycle.
REQ-038 Reset during PRESENT with vector 2 -> next cycle cpu_exception=0, pending=0, mask=MASK_RST.

Source files
------------

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: per-source edge/level capture, enable mask,
// lowest-index-wins arbitration and a two-state present/ack handshake to the CPU.
module interrupt_controller #(
  parameter int              NSRC     = 8,
  parameter int              EXW      = 4,
  parameter logic [NSRC-1:0] EDGE     = '0,
  parameter logic [NSRC-1:0] MASK_RST = '1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] src,
  input  logic            enabled,
  input  logic            ack,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic [EXW-1:0]  cpu_exception,
  output logic            irq
);

  // Vector 0 means "none", so NSRC must fit in 1..2^EXW-1.
  if (NSRC < 1 || NSRC > (1 << EXW) - 1) begin : g_bad_params
    $error("interrupt_controller: NSRC=%0d does not fit EXW=%0d", NSRC, EXW);
  end

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t          state_q, state_d;
  logic [EXW-1:0]  vec_q, vec_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] mask_q;
  logic            armed_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] eligible;
  logic [EXW-1:0]  win_idx;

  // armed_q suppresses edge detection on the first cycle out of reset, so a
  // source already high at release is not mistaken for a new rising edge.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign rise[gi]      = src[gi] & ~prev_q[gi] & armed_q;
      assign clr[gi]       = (state_q == PRESENT) && ack && (vec_q == EXW'(gi + 1));
      assign pending_d[gi] = EDGE[gi] ? (rise[gi] | (pending_q[gi] & ~clr[gi])) : src[gi];
    end
  endgenerate

  assign eligible = pending_q & mask_q;

  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = EXW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      prev_q    <= '0;
      mask_q    <= MASK_RST;
      armed_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      prev_q    <= src;
      armed_q   <= 1'b1;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // The presented vector is frozen in PRESENT; leaving always passes through IDLE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        vec_d = '0;
        if (enabled && |eligible) begin
          state_d = PRESENT;
          vec_d   = win_idx + EXW'(1);
        end
      end
      PRESENT: begin
        if (ack || !enabled) begin
          state_d = IDLE;
          vec_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_comb begin
    cpu_exception = vec_q;
    irq           = (vec_q != '0);
    mask          = mask_q;
    pending       = pending_q;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: bit 5 is level-mode, all others edge-mode.
module tb_interrupt_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] src;
  logic       enabled;
  logic       ack;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [3:0] cpu_exception;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_controller #(
    .NSRC(8), .EXW(4), .EDGE(8'hDF), .MASK_RST(8'hFF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .src(src), .enabled(enabled), .ack(ack),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask), .pending(pending),
    .cpu_exception(cpu_exception), .irq(irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; src = 8'h02; enabled = 1'b1; ack = 1'b0;
    mask_we = 1'b0; mask_wdata = 8'h00;
    tick(); tick();
    check("rst_cpu_exc", 32'(cpu_exception), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_mask", 32'(mask), 32'hFF);

    // Source 1 already high at reset release must not latch
    rst_i = 1'b0;
    tick();
    check("rel_pending_c1", 32'(pending), 32'h0);
    tick();
    check("rel_pending_c2", 32'(pending), 32'h0);
    check("rel_cpu_exc", 32'(cpu_exception), 32'h0);
    src = 8'h00; tick();

    // Level source 5 pulse
    src = 8'h20; tick();
    check("lvl_pending", 32'(pending), 32'h20);
    check("lvl_cpu_exc_0", 32'(cpu_exception), 32'h0);
    src = 8'h00; tick();
    check("lvl_cpu_exc", 32'(cpu_exception), 32'h6);
    check("lvl_irq", 32'(irq), 32'h1);
    ack = 1'b1; tick();
    check("lvl_ack_exc", 32'(cpu_exception), 32'h0);
    check("lvl_ack_pend", 32'(pending), 32'h0);
    ack = 1'b0;

    // Simultaneous edges on 2 and 6
    src = 8'h44; tick();
    check("pri_pending", 32'(pending), 32'h44);
    src = 8'h00; tick();
    check("pri_exc3", 32'(cpu_exception), 32'h3);
    ack = 1'b1; tick();
    check("pri_idle_gap", 32'(cpu_exception), 32'h0);
    check("pri_pend_after_ack", 32'(pending), 32'h40);
    ack = 1'b0; tick();
    check("pri_exc7", 32'(cpu_exception), 32'h7);

    // Hold against higher priority, then retract
    src = 8'h01; tick();
    check("hold_exc7_a", 32'(cpu_exception), 32'h7);
    src = 8'h00; tick();
    check("hold_exc7_b", 32'(cpu_exception), 32'h7);
    enabled = 1'b0; tick();
    check("retract_exc", 32'(cpu_exception), 32'h0);
    check("retract_pend", 32'(pending), 32'h41);
    enabled = 1'b1; tick();
    check("drain_exc1", 32'(cpu_exception), 32'h1);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check("drain_exc7", 32'(cpu_exception), 32'h7);
    ack = 1'b1; tick();
    check("drain_pend", 32'(pending), 32'h0);
    ack = 1'b0;

    // Masked source keeps pending but is not presented
    mask_we = 1'b1; mask_wdata = 8'hFE; tick();
    check("mask_fe", 32'(mask), 32'hFE);
    mask_we = 1'b0; src = 8'h01; tick();
    check("mask_pend", 32'(pending), 32'h01);
    src = 8'h00; tick();
    check("mask_exc0_a", 32'(cpu_exception), 32'h0);
    tick();
    check("mask_exc0_b", 32'(cpu_exception), 32'h0);
    mask_we = 1'b1; mask_wdata = 8'hFF; tick();
    check("mask_ff", 32'(mask), 32'hFF);
    mask_we = 1'b0; tick();
    check("unmask_exc1", 32'(cpu_exception), 32'h1);
    ack = 1'b1; tick();
    ack = 1'b0;

    // New edge on 3 in the ack cycle of vector 4
    src = 8'h08; tick();
    src = 8'h00; tick();
    check("coll_exc4", 32'(cpu_exception), 32'h4);
    src = 8'h08; ack = 1'b1; tick();
    check("coll_exc0", 32'(cpu_exception), 32'h0);
    check("coll_pend", 32'(pending), 32'h08);
    ack = 1'b0; tick();
    check("coll_reexc4", 32'(cpu_exception), 32'h4);
    src = 8'h00; ack = 1'b1; tick();
    check("coll_pend_clr", 32'(pending), 32'h0);
    ack = 1'b0;

    // Ack while idle is ignored
    src = 8'h10; tick();
    src = 8'h00; ack = 1'b1; tick();
    check("idle_ack_exc5", 32'(cpu_exception), 32'h5);
    check("idle_ack_pend", 32'(pending), 32'h10);
    tick();
    check("ack5_exc0", 32'(cpu_exception), 32'h0);
    ack = 1'b0;

    // Reset in the middle of presenting vector 2
    src = 8'h02; mask_we = 1'b1; mask_wdata = 8'h0F; tick();
    src = 8'h00; mask_we = 1'b0; tick();
    check("pre_rst_exc2", 32'(cpu_exception), 32'h2);
    check("pre_rst_mask", 32'(mask), 32'h0F);
    rst_i = 1'b1; tick();
    check("midrst_exc", 32'(cpu_exception), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_pend", 32'(pending), 32'h0);
    check("midrst_mask", 32'(mask), 32'hFF);
    rst_i = 1'b0; tick();
    check("post_rst_exc", 32'(cpu_exception), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
